// File: rtl/pipe_mux_rr_pkg.sv
// pipe_mux_rr_pkg: shared mode encodings for the pipelined channel mux
package pipe_mux_rr_pkg;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR = 1'b1;
endpackage

// File: rtl/pipe_mux_rr_rr_arbiter.sv
// rr_arbiter: first requesting channel after ptr, searching modulo CHANNELS
module rr_arbiter
  import pipe_mux_rr_pkg::*;
#(
  parameter int CHANNELS = 6,
  parameter int SELW = 3
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     ptr,
  output logic [SELW-1:0]     gnt,
  output logic                found
);
  logic [2**SELW-1:0] req_pad;
  logic [SELW-1:0] idx;
  assign req_pad = (2**SELW)'(req);
  // scan from farthest to nearest so the closest request after ptr wins
  always_comb begin
    gnt = '0;
    found = 1'b0;
    idx = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      idx = SELW'((int'(ptr) + k) % CHANNELS);
      if (req_pad[idx]) begin
        gnt = idx;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pipe_mux_rr.sv
// pipe_mux_rr: registered channel mux with direct or round-robin selection
module pipe_mux_rr
  import pipe_mux_rr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHANNELS = 6,
  parameter int SELW = 3
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SELW-1:0]           select,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SELW-1:0]           out_chan
);
  logic [SELW-1:0] ptr, rr_gnt, gnt;
  logic rr_found, has_gnt, load, rr;
  logic [2**SELW-1:0] valid_pad;
  logic [WIDTH-1:0] words [2**SELW];
  rr_arbiter #(.CHANNELS(CHANNELS), .SELW(SELW)) u_arb (
    .req(in_valid), .ptr(ptr), .gnt(rr_gnt), .found(rr_found)
  );
  assign rr = mode == MODE_RR;
  assign valid_pad = (2**SELW)'(in_valid);
  // unused slots read as zero so an out-of-range index never selects junk
  always_comb begin
    words = '{default: '0};
    for (int i = 0; i < CHANNELS; i++) words[i] = in_data[i*WIDTH +: WIDTH];
  end
  // direct select only grants an in-range, valid channel
  always_comb begin
    gnt = rr ? rr_gnt : select;
    has_gnt = rr ? rr_found : (int'(select) < CHANNELS) && valid_pad[select];
    load = !reset && (!out_valid || out_ready) && has_gnt;
    in_ready = load ? CHANNELS'(1) << gnt : '0;
  end
  // output register and round-robin pointer
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      out <= '0;
      out_valid <= 1'b0;
      out_chan <= '0;
      ptr <= SELW'(CHANNELS - 1);
    end else if (load) begin
      out <= words[gnt];
      out_chan <= gnt;
      out_valid <= 1'b1;
      if (rr) ptr <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pipe_mux_rr.sv
// tb_pipe_mux_rr: directed and randomized checks against a behavioural model
module tb_pipe_mux_rr;
  localparam int W = 16, CH = 6, SW = 3;
  logic CLK = 0, reset = 1, mode = 0, out_ready = 0, out_valid;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0] in_valid = '0, in_ready;
  logic [SW-1:0] select = '0, out_chan;
  logic [W-1:0] out;
  int checks = 0, errors = 0;
  int m_out = 0, m_chan = 0, m_ptr = CH - 1;
  bit m_valid = 0;
  int vals [CH] = '{1, 3, 7, 15, 31, 63};

  pipe_mux_rr #(.WIDTH(W), .CHANNELS(CH), .SELW(SW)) dut (
    .CLK(CLK), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .select(select), .out(out),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
  );

  always #5 CLK = ~CLK;

  function automatic void grant(output bit has, output int g);
    has = 0;
    g = 0;
    if (mode) begin
      for (int k = 1; k <= CH; k++)
        if (!has && in_valid[(m_ptr + k) % CH]) begin
          has = 1;
          g = (m_ptr + k) % CH;
        end
    end else begin
      g = int'(select);
      has = g < CH && in_valid[g % CH];
    end
  endfunction

  function automatic bit model_load(output int g);
    bit has;
    grant(has, g);
    return !reset && (!m_valid || out_ready) && has;
  endfunction

  always @(posedge CLK or posedge reset) begin
    int g;
    if (reset) begin
      m_out = 0; m_valid = 0; m_chan = 0; m_ptr = CH - 1;
    end else if (model_load(g)) begin
      m_out = int'(in_data[g*W +: W]);
      m_chan = g;
      m_valid = 1;
      if (mode) m_ptr = g;
    end else if (out_ready) m_valid = 0;
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    int g;
    int exp_rdy;
    exp_rdy = model_load(g) ? (1 << g) : 0;
    chk("model in_ready", int'(in_ready), exp_rdy);
    chk("model out_valid", int'(out_valid), int'(m_valid));
    chk("model out", int'(out), m_out);
    chk("model out_chan", int'(out_chan), m_chan);
  end

  task automatic edge1();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_vals();
    for (int i = 0; i < CH; i++) in_data[i*W +: W] = W'(vals[i]);
  endtask

  task automatic pulse_reset();
    reset = 1;
    edge1();
    reset = 0;
  endtask

  initial begin
    set_vals();
    #2;
    chk("reset out", int'(out), 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_chan", int'(out_chan), 0);
    chk("reset in_ready", int'(in_ready), 0);
    edge1();
    reset = 0;
    in_valid = '1;
    out_ready = 1;
    for (int s = 0; s < CH; s++) begin
      select = SW'(s);
      edge1();
      chk("direct out", int'(out), vals[s]);
      chk("direct out_chan", int'(out_chan), s);
    end
    select = 3'd6;
    #1 chk("oor in_ready", int'(in_ready), 0);
    edge1();
    chk("oor out_valid", int'(out_valid), 0);
    chk("oor out", int'(out), 63);
    pulse_reset();
    mode = 1;
    for (int s = 0; s <= CH; s++) begin
      edge1();
      chk("rr out_chan", int'(out_chan), s % CH);
      chk("rr out", int'(out), vals[s % CH]);
    end
    pulse_reset();
    in_valid = 6'b100100;
    edge1();
    chk("rr2 first", int'(out), 7);
    out_ready = 0;
    repeat (3) begin
      #1 chk("stall in_ready", int'(in_ready), 0);
      edge1();
      chk("stall out", int'(out), 7);
    end
    out_ready = 1;
    edge1();
    chk("rr2 next", int'(out), 63);
    edge1();
    chk("rr2 wrap", int'(out), 7);
    pulse_reset();
    in_valid = '1;
    repeat (5) edge1();
    chk("pre-reset out", int'(out), 31);
    out_ready = 0;
    #2 reset = 1;
    #1;
    chk("async out", int'(out), 0);
    chk("async out_valid", int'(out_valid), 0);
    chk("async in_ready", int'(in_ready), 0);
    edge1();
    reset = 0;
    edge1();
    chk("post-reset chan", int'(out_chan), 0);
    mode = 0;
    select = 3'd4;
    edge1();
    chk("held over mode", int'(out), 1);
    out_ready = 1;
    edge1();
    chk("direct after rr", int'(out), 31);
    chk("direct after rr chan", int'(out_chan), 4);
    mode = 1;
    edge1();
    chk("ptr kept", int'(out_chan), 1);
    for (int n = 0; n < 600; n++) begin
      in_data = {$urandom, $urandom, $urandom};
      in_valid = CH'($urandom);
      if ($urandom_range(0, 3) == 0) in_valid = '0;
      mode = 1'($urandom);
      select = SW'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 60) == 0) begin
        #2 reset = 1;
        #2 reset = 0;
      end
      edge1();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_mux_rr.md
PIPE_MUX_RR -- requirements
Module: pipe_mux_rr

Interface
REQ-001 Parameter WIDTH, default 16, data width of every channel and of out.
REQ-002 Parameter CHANNELS, default 6, number of input channels (2..16).
REQ-003 Parameter SELW, default 3, width of select and out_chan; SHALL satisfy 2^SELW >= CHANNELS.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  CHANNELS*WIDTH  flattened channel words; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  CHANNELS  per-channel word-available flag.
REQ-008 in_ready  output  CHANNELS  per-channel accept strobe; one-hot or zero.
REQ-009 mode  input  1  0 = direct select, 1 = round-robin.
REQ-010 select  input  SELW  channel index used in direct mode.
REQ-011 out  output  WIDTH  registered selected word.
REQ-012 out_valid  output  1  out holds an unconsumed word.
REQ-013 out_ready  input  1  downstream accepts out this cycle.
REQ-014 out_chan  output  SELW  index of channel that supplied out.

Function
REQ-015 Load condition: output register SHALL load on a clock edge iff (out_valid==0 or out_ready==1) and a grant exists.
REQ-016 Direct mode grant: channel select, only if select < CHANNELS and in_valid[select]==1; otherwise no grant.
REQ-017 Out-of-range select (select >= CHANNELS) SHALL produce no grant, no in_ready, and leave out/out_chan unchanged.
REQ-018 Round-robin grant: first channel with in_valid==1 searching ptr+1, ptr+2, ... modulo CHANNELS, ending at ptr.
REQ-019 ptr SHALL update to the granted index only on a round-robin load; wrap CHANNELS-1 -> 0.
REQ-020 ptr SHALL NOT change on direct-mode loads or idle cycles.
REQ-021 in_ready[g] SHALL be 1, combinationally, exactly in a cycle where load occurs with grant g; all other bits 0.
REQ-022 Latency: word accepted at edge k SHALL appear on out with out_valid=1 after edge k (one cycle).
REQ-023 While out_valid==1 and out_ready==0: out, out_chan held stable; in_ready all 0.
REQ-024 Simultaneous drain and load (out_valid=1, out_ready=1, grant present): new word replaces old in same edge; out_valid stays 1; full throughput one word per cycle.
REQ-025 Drain without grant: out_valid SHALL clear to 0; out and out_chan retain last value.
REQ-026 Changes of mode or select while a word is held SHALL not alter the held word.
REQ-027 in_data/in_valid on non-granted channels SHALL have no effect.

Reset
REQ-028 While reset is high: out=0, out_valid=0, out_chan=0, ptr=CHANNELS-1, in_ready=0, independent of CLK.
REQ-029 Reset asserted mid-transfer SHALL discard the held word; first round-robin grant after reset SHALL start search at channel 0.

Structure
REQ-030 Mode encodings MODE_DIRECT=0 and MODE_RR=1 SHALL live in the shared constants package/include used by the datapath units.
REQ-031 Round-robin search logic SHALL be a sub-module rr_arbiter (inputs: request vector, ptr; outputs: grant index, grant-found).
REQ-032 Top level holds output register, ptr register, direct-mode qualification and in_ready decode.

Verification
REQ-033 Direct mode, in_data ch0..5 = 1,3,7,15,31,63, all valid, out_ready=1, select stepped 0..5 every cycle -> out = 1,3,7,15,31,63 one cycle later, out_chan = select.
REQ-034 Direct mode, select=6 after out=63 -> no in_ready, out_valid drops to 0 after one edge, out stays 63.
REQ-035 RR mode after reset, all six valid, out_ready=1 -> out_chan sequence 0,1,2,3,4,5,0 on consecutive cycles, out = 1,3,7,15,31,63,1.
REQ-036 RR mode, only ch2 and ch5 valid, out_ready held 0 for 3 cycles after first load -> out=7 stable, in_ready=0; on release next out=63 then 7.
REQ-037 Reset pulsed while out_valid=1 with out=31 -> out=0, out_valid=0 immediately; next RR grant with all valid is channel 0.
REQ-038 Mode switched from RR to direct (select=4) while word held -> held word unchanged; next load gives out=31, ptr unchanged.
